ext_mem_rd_dma: RTL
===================

Name: ext_mem_rd_dma

Overview:
- Read-side DMA engine for the external memory image that holds the inference configuration, input feature map, output feature map and the expansion, pointwise and depthwise kernels, each at a fixed byte base.
- Accepts one read command at a time: a region, a byte offset and a word count.
- Splits the command into bursts of at most BURST_MAX words, issues them to the memory port and buffers the returned words in a local FIFO.
- Streams the words to the on-chip consumer with valid/ready handshake and a last marker.

Parameters:
- ADDR_W, 27, external byte-address width (covers the 0..103 MiB map).
- DATA_W, 32, word width; one word is 4 bytes.
- LEN_W, 16, width of the command word count.
- BURST_MAX, 16, maximum words per memory burst.
- FIFO_DEPTH, 32, local buffer depth in words; must be ≥ BURST_MAX.
- BASE_INF, 0, region 0 base (inference configuration).
- BASE_FMI, 2*2^20, region 1 base (input feature map).
- BASE_FMO, 24*2^20, region 2 base (output feature map).
- BASE_KEX, 46*2^20, region 3 base (expansion kernels).
- BASE_KPW, 66*2^20, region 4 base (pointwise kernels).
- BASE_KDW, 84*2^20, region 5 base (depthwise kernels).
- BASE_END, 103*2^20, upper limit of region 5.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command (high only in IDLE).
- cmd_region  in  3  region select 0..5; 6 and 7 are illegal.
- cmd_offset  in  ADDR_W  byte offset within the region.
- cmd_len  in  LEN_W  number of words to read.
- mem_req_valid  out  1  burst request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  burst start byte address.
- mem_req_len  out  5  burst word count, 1..BURST_MAX.
- mem_rsp_valid  in  1  read data beat; there is no backpressure on this port.
- mem_rsp_data  in  DATA_W  read data.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  output word.
- out_last  out  1  marks the final word of the command.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (asynchronous, any state):
  - All outputs are 0, except cmd_ready, which is 1.
  - The FIFO and all counters are cleared and the state goes to IDLE.
  - Any response beats arriving after reset are ignored.
- Region limit: each region's limit is the next region's base; region 5's limit is BASE_END.
- Command acceptance (IDLE, cmd_valid & cmd_ready):
  - Inputs are latched.
  - The command is rejected (err pulse next cycle, state stays IDLE, no memory traffic) if any of these hold:
    - region > 5;
    - cmd_offset[1:0] ≠ 0;
    - base + offset + 4·len > region limit.
  - If cmd_len = 0: done pulses next cycle; no memory traffic.
  - Otherwise: addr = base + offset, remaining = len, state goes to ISSUE.
- ISSUE:
  - blen = min(remaining, BURST_MAX).
  - mem_req_valid is asserted only when FIFO free slots ≥ blen, which guarantees that the non-backpressured response always fits.
  - mem_req_addr and mem_req_len stay stable until mem_req_ready.
  - On the handshake: addr += 4·blen, remaining -= blen, state goes to RECV.
  - Earliest mem_req_valid is the cycle after command acceptance.
- RECV:
  - Every mem_rsp_valid beat is written to the FIFO.
  - After blen beats: if remaining > 0, state goes to ISSUE; otherwise state goes to DRAIN.
  - At most one burst is outstanding.
  - mem_rsp_valid outside RECV is ignored.
- Output path:
  - A word written in cycle T is visible on out_valid at T+1.
  - out_data and out_valid are held stable while out_ready = 0.
  - FIFO push and pop in the same cycle keep the occupancy unchanged.
  - out_last is high with the word whose output count equals cmd_len.
- DRAIN: on the out_last handshake, done pulses the next cycle and the state returns to IDLE (busy low in the same cycle as done).
- Width rules:
  - Address arithmetic is ADDR_W wide and never wraps, because the limit check precedes issue.
  - The word counter is LEN_W wide.
- FIFO full while in RECV cannot occur by construction; the bench asserts this.

Test Plan:
- Region 1, offset 0, len 4, mem_req_ready = 1 → one request: addr 0x200000, len 4. Four words out in order, out_last on the 4th; done one cycle after the last handshake.
- Region 4, offset 0x40, len 37 → requests at 0x4200040 (len 16), 0x4200080 (len 16) and 0x42000C0 (len 5). 37 words out with out_last only on the 37th.
- Region 5, offset 0x12FFFF0, len 4 → accepted, ending exactly at BASE_END. Same region with len 5 → err pulse, no mem_req_valid, done stays 0.
- Region 6 or offset 0x2 → err pulse one cycle after acceptance; cmd_ready remains 1.
- Region 2, len 48 with out_ready held 0 → after 32 words buffered, no further request. Releasing out_ready → the third burst is issued once 16 slots are free; all 48 words out, none lost.
- Reset asserted mid-RECV (burst 2 of 3) → all outputs 0 immediately, cmd_ready 1. Stray mem_rsp_valid beats are ignored; a new len-1 command completes normally.

Source files
------------

// File: rtl/ext_mem_rd_dma.sv
// Read-side DMA for the external memory image: splits a region/offset/length
// command into bounded bursts, buffers returned words and streams them out.
module ext_mem_rd_dma #(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned BURST_MAX  = 16,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned BASE_INF   = 0,
  parameter int unsigned BASE_FMI   = 2 * (2 ** 20),
  parameter int unsigned BASE_FMO   = 24 * (2 ** 20),
  parameter int unsigned BASE_KEX   = 46 * (2 ** 20),
  parameter int unsigned BASE_KPW   = 66 * (2 ** 20),
  parameter int unsigned BASE_KDW   = 84 * (2 ** 20),
  parameter int unsigned BASE_END   = 103 * (2 ** 20)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_region,
  input  logic [ADDR_W-1:0] cmd_offset,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [4:0]        mem_req_len,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Limit check width holds base + offset + 4*len without overflow.
  localparam int unsigned CW = ((ADDR_W > LEN_W + 2) ? ADDR_W : LEN_W + 2) + 2;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RECV, DRAIN} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  out_cnt;
  logic [4:0]        burst_len;
  logic [4:0]        beat_cnt;
  logic [4:0]        blen;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       fifo_cnt;
  logic [PW:0]       fifo_free;

  logic [CW-1:0]     sel_base, sel_limit, cmd_end;
  logic              region_ok, cmd_bad;
  logic              accept, req_fire, push, pop, room, last_beat;

  always_comb begin
    sel_base  = '0;
    sel_limit = '0;
    region_ok = 1'b1;
    case (cmd_region)
      3'd0: begin sel_base = CW'(BASE_INF); sel_limit = CW'(BASE_FMI); end
      3'd1: begin sel_base = CW'(BASE_FMI); sel_limit = CW'(BASE_FMO); end
      3'd2: begin sel_base = CW'(BASE_FMO); sel_limit = CW'(BASE_KEX); end
      3'd3: begin sel_base = CW'(BASE_KEX); sel_limit = CW'(BASE_KPW); end
      3'd4: begin sel_base = CW'(BASE_KPW); sel_limit = CW'(BASE_KDW); end
      3'd5: begin sel_base = CW'(BASE_KDW); sel_limit = CW'(BASE_END); end
      default: region_ok = 1'b0;
    endcase
  end

  assign cmd_end = sel_base + CW'(cmd_offset) + (CW'(cmd_len) << 2);
  assign cmd_bad = !region_ok || (cmd_offset[1:0] != 2'b00) || (cmd_end > sel_limit);

  assign blen      = (remaining > LEN_W'(BURST_MAX)) ? 5'(BURST_MAX) : 5'(remaining);
  assign fifo_free = (PW + 1)'(FIFO_DEPTH) - fifo_cnt;
  // Requesting only when the whole burst fits keeps the unthrottled response safe.
  assign room      = fifo_free >= (PW + 1)'(blen);
  assign last_beat = (beat_cnt == burst_len - 5'd1);

  assign accept   = cmd_valid && (state == IDLE);
  assign req_fire = mem_req_valid && mem_req_ready;
  assign push     = (state == RECV) && mem_rsp_valid;
  assign pop      = out_valid && out_ready;

  assign mem_req_addr = addr_q;
  assign mem_req_len  = blen;
  assign busy         = (state != IDLE);
  assign out_valid    = (fifo_cnt != '0);
  assign out_data     = out_valid ? fifo_mem[rd_ptr] : '0;
  assign out_last     = out_valid && (out_cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d       = state;
    cmd_ready     = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_bad && (cmd_len != '0)) state_d = ISSUE;
      end
      ISSUE: begin
        mem_req_valid = room;
        if (room && mem_req_ready) state_d = RECV;
      end
      RECV: begin
        if (push && last_beat) state_d = (remaining != '0) ? ISSUE : DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      remaining <= '0;
      len_q     <= '0;
      out_cnt   <= '0;
      burst_len <= '0;
      beat_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        if (cmd_bad) begin
          err <= 1'b1;
        end else if (cmd_len == '0) begin
          done <= 1'b1;
        end else begin
          addr_q    <= sel_base[ADDR_W-1:0] + cmd_offset;
          remaining <= cmd_len;
          len_q     <= cmd_len;
          out_cnt   <= '0;
        end
      end
      if (req_fire) begin
        addr_q    <= addr_q + ADDR_W'({blen, 2'b00});
        remaining <= remaining - LEN_W'(blen);
        burst_len <= blen;
        beat_cnt  <= '0;
      end
      if (push) beat_cnt <= beat_cnt + 5'd1;
      if (pop)  out_cnt  <= out_cnt + LEN_W'(1);
      if ((state == DRAIN) && pop && out_last) done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rsp_data;
  end

endmodule
